// File: rtl/mul_seq_unit_pkg.sv
// Shared definitions for the sequential multiplier.
// State encodings and default operand width.
package mul_seq_unit_pkg;

  localparam int MUL_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_seq_unit.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle.
// Low half is written back into regA, high half held on productHi.
module mul_seq_unit
  import mul_seq_unit_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic             loadA,
  output logic [WIDTH-1:0] dataAin,
  output logic [WIDTH-1:0] productHi
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic load_q, load_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH:0] sum;

  // Partial-product add on the upper accumulator half, carry kept.
  always_comb begin
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (mplier_q[0]) begin
      sum = sum + {1'b0, mcand_q};
    end
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load_d   = 1'b0;
    lo_d     = lo_q;
    hi_d     = hi_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d  = RUN;
          mcand_d  = opA;
          mplier_d = opB;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        busy_d   = 1'b1;
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        load_d  = 1'b1;
        lo_d    = acc_q[WIDTH-1:0];
        hi_d    = acc_q[2*WIDTH-1:WIDTH];
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      load_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      load_q   <= load_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign loadA     = load_q;
  assign dataAin   = lo_q;
  assign productHi = hi_q;

endmodule
